// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with valid/ready handshake and a two-entry skid buffer.
// Ready/valid are decoded from registered state only, so MEM stalls never reach EX combinationally.
module ex_mem_skid_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  RegWrite_i,
    input  logic                  MemToReg_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic [DATA_W-1:0]     ALUresult_i,
    input  logic [DATA_W-1:0]     Readdata2_i,
    input  logic [REG_ADDR_W-1:0] RdAddr_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  RegWrite_o,
    output logic                  MemToReg_o,
    output logic                  MemRead_o,
    output logic                  MemWrite_o,
    output logic [DATA_W-1:0]     ALUresult_o,
    output logic [DATA_W-1:0]     Readdata2_o,
    output logic [REG_ADDR_W-1:0] RdAddr_o,
    output logic [1:0]            count_o
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_read;
        logic                  mem_write;
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     rd2;
        logic [REG_ADDR_W-1:0] rd;
    } ent_t;

    state_e state_q, state_d;
    ent_t   main_q, main_d, skid_q, skid_d, in_ent;
    logic   in_xfer, out_xfer;

    function automatic ent_t clr_ctrl(input ent_t e);
        ent_t r;
        r            = e;
        r.reg_write  = 1'b0;
        r.mem_to_reg = 1'b0;
        r.mem_read   = 1'b0;
        r.mem_write  = 1'b0;
        return r;
    endfunction

    assign ready_o  = (state_q != FULL);
    assign valid_o  = (state_q != EMPTY);
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    always_comb begin
        in_ent.reg_write  = RegWrite_i;
        in_ent.mem_to_reg = MemToReg_i;
        in_ent.mem_read   = MemRead_i;
        in_ent.mem_write  = MemWrite_i;
        in_ent.alu        = ALUresult_i;
        in_ent.rd2        = Readdata2_i;
        in_ent.rd         = RdAddr_i;
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // Squash: both entries become bubbles; data fields are left as-is.
            state_d = EMPTY;
            main_d  = clr_ctrl(main_q);
            skid_d  = clr_ctrl(skid_q);
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_ent;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_ent;
                    end else if (in_xfer) begin
                        skid_d  = in_ent;
                        state_d = FULL;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign RegWrite_o  = main_q.reg_write  & valid_o;
    assign MemToReg_o  = main_q.mem_to_reg & valid_o;
    assign MemRead_o   = main_q.mem_read   & valid_o;
    assign MemWrite_o  = main_q.mem_write  & valid_o;
    assign ALUresult_o = main_q.alu;
    assign Readdata2_o = main_q.rd2;
    assign RdAddr_o    = main_q.rd;
    assign count_o     = state_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: directed scenarios plus random traffic against a 2-deep FIFO model.
module tb_ex_mem_skid_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
    logic        rw_i = 1'b0, mtr_i = 1'b0, mr_i = 1'b0, mw_i = 1'b0;
    logic [31:0] alu_i = '0, rd2_i = '0;
    logic [4:0]  rd_i = '0;
    logic        ready_o, valid_o, rw_o, mtr_o, mr_o, mw_o;
    logic [31:0] alu_o, rd2_o;
    logic [4:0]  rd_o;
    logic [1:0]  count_o;

    // Wide instance for the parameter sweep.
    logic        w_valid_i = 1'b0;
    logic [63:0] w_alu_i = '0;
    logic [5:0]  w_rd_i = '0;
    logic        w_ready_o, w_valid_o, w_rw_o, w_mtr_o, w_mr_o, w_mw_o;
    logic [63:0] w_alu_o, w_rd2_o;
    logic [5:0]  w_rd_o;
    logic [1:0]  w_count_o;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ex_mem_skid_reg u_dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .RegWrite_i(rw_i), .MemToReg_i(mtr_i), .MemRead_i(mr_i), .MemWrite_i(mw_i),
        .ALUresult_i(alu_i), .Readdata2_i(rd2_i), .RdAddr_i(rd_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .RegWrite_o(rw_o), .MemToReg_o(mtr_o), .MemRead_o(mr_o), .MemWrite_o(mw_o),
        .ALUresult_o(alu_o), .Readdata2_o(rd2_o), .RdAddr_o(rd_o), .count_o(count_o)
    );

    ex_mem_skid_reg #(.DATA_W(64), .REG_ADDR_W(6)) u_dut64 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .valid_i(w_valid_i), .ready_o(w_ready_o),
        .RegWrite_i(1'b1), .MemToReg_i(1'b0), .MemRead_i(1'b0), .MemWrite_i(1'b0),
        .ALUresult_i(w_alu_i), .Readdata2_i(64'h0), .RdAddr_i(w_rd_i),
        .valid_o(w_valid_o), .ready_i(1'b1),
        .RegWrite_o(w_rw_o), .MemToReg_o(w_mtr_o), .MemRead_o(w_mr_o), .MemWrite_o(w_mw_o),
        .ALUresult_o(w_alu_o), .Readdata2_o(w_rd2_o), .RdAddr_o(w_rd_o), .count_o(w_count_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    endtask

    // Behavioural model: an in-order queue of at most two entries.
    typedef struct {
        bit          rw, mtr, mr, mw;
        logic [31:0] alu, rd2;
        logic [4:0]  rd;
    } ent_t;
    ent_t mq[$];
    bit   m_in, m_out;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            m_in  = valid_i && (mq.size() < 2);
            m_out = (mq.size() > 0) && ready_i;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (m_out) void'(mq.pop_front());
                if (m_in) mq.push_back('{rw_i, mtr_i, mr_i, mw_i, alu_i, rd2_i, rd_i});
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("m_count", {62'd0, count_o}, 64'(mq.size()));
            chk("m_valid", {63'd0, valid_o}, {63'd0, mq.size() != 0});
            chk("m_ready", {63'd0, ready_o}, {63'd0, mq.size() < 2});
            if (mq.size() != 0) begin
                chk("m_ctrl", {60'd0, rw_o, mtr_o, mr_o, mw_o},
                    {60'd0, mq[0].rw, mq[0].mtr, mq[0].mr, mq[0].mw});
                chk("m_alu", {32'd0, alu_o}, {32'd0, mq[0].alu});
                chk("m_rd2", {32'd0, rd2_o}, {32'd0, mq[0].rd2});
                chk("m_rd",  {59'd0, rd_o},  {59'd0, mq[0].rd});
            end else begin
                chk("m_ctrl_bubble", {60'd0, rw_o, mtr_o, mr_o, mw_o}, 64'd0);
            end
        end
    end

    task automatic step(input bit v, input bit rdy, input bit fl, input bit rw, input bit mw,
                        input logic [31:0] alu, input logic [4:0] rd);
        valid_i = v; ready_i = rdy; flush_i = fl;
        rw_i = rw; mtr_i = 1'b0; mr_i = 1'b0; mw_i = mw;
        alu_i = alu; rd2_i = ~alu; rd_i = rd;
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, {63'd0, valid_o}, 64'd0);
        chk({tag, "_ready"}, {63'd0, ready_o}, 64'd1);
        chk({tag, "_count"}, {62'd0, count_o}, 64'd0);
        chk({tag, "_ctrl"},  {60'd0, rw_o, mtr_o, mr_o, mw_o}, 64'd0);
        chk({tag, "_data"},  {alu_o, rd2_o}, 64'd0);
        chk({tag, "_rd"},    {59'd0, rd_o}, 64'd0);
    endtask

    initial begin
        #2;
        chk_reset_outs("reset");
        #10 rst = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Streaming at full rate
        for (int i = 1; i <= 4; i++) begin
            step(1, 1, 0, 1, 0, 32'(i * 16), 5'(i));
            chk("stream_alu", {32'd0, alu_o}, 64'(i * 16));
            chk("stream_count", {62'd0, count_o}, 64'd1);
            chk("stream_ready", {63'd0, ready_o}, 64'd1);
        end
        step(0, 1, 0, 0, 0, 0, 0);
        chk("stream_drain", {62'd0, count_o}, 64'd0);

        // Skid fill and drain
        step(1, 1, 0, 1, 0, 32'hA, 5'd3);
        step(1, 0, 0, 1, 0, 32'hB, 5'd7);
        chk("skid_count", {62'd0, count_o}, 64'd2);
        chk("skid_ready", {63'd0, ready_o}, 64'd0);
        chk("skid_showA", {59'd0, rd_o}, 64'd3);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 1, 32'hDEAD, 5'd9);
            chk("hold_count", {62'd0, count_o}, 64'd2);
            chk("hold_rd", {59'd0, rd_o}, 64'd3);
        end
        step(0, 1, 0, 0, 0, 0, 0);
        chk("skid_showB", {59'd0, rd_o}, 64'd7);
        chk("skid_B_alu", {32'd0, alu_o}, 64'hB);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("skid_empty", {62'd0, count_o}, 64'd0);

        // Flush while FULL with MemWrite set in both entries
        step(1, 0, 0, 0, 1, 32'h111, 5'd1);
        step(1, 0, 0, 0, 1, 32'h222, 5'd2);
        chk("pre_flush_count", {62'd0, count_o}, 64'd2);
        step(1, 1, 1, 1, 1, 32'h333, 5'd21);
        chk("flush_valid", {63'd0, valid_o}, 64'd0);
        chk("flush_mw", {63'd0, mw_o}, 64'd0);
        chk("flush_count", {62'd0, count_o}, 64'd0);
        chk("flush_ready", {63'd0, ready_o}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1, 1, 32'h444, 5'd22);
            chk("flush_gone", {63'd0, valid_o}, 64'd0);
        end

        // Bubbles never write
        for (int i = 0; i < 3; i++) begin
            step(0, i[0], 0, 1, 1, 32'h555, 5'd4);
            chk("bubble_rw", {63'd0, rw_o}, 64'd0);
            chk("bubble_mw", {63'd0, mw_o}, 64'd0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            valid_i = 1'($urandom_range(0, 1));
            ready_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 15) == 0);
            {rw_i, mtr_i, mr_i, mw_i} = 4'($urandom);
            alu_i = $urandom; rd2_i = $urandom; rd_i = 5'($urandom);
            @(posedge clk); #1;
        end

        // Async reset between edges while FULL
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 1, 32'h777, 5'd5);
        step(1, 0, 0, 1, 1, 32'h888, 5'd6);
        chk("pre_rst_count", {62'd0, count_o}, 64'd2);
        valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_reset_outs("async_rst");
        @(posedge clk); #1;
        chk_reset_outs("held_rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // Wide-parameter pass-through
        w_valid_i = 1'b1; w_alu_i = 64'hFFFF_0000_1234_5678; w_rd_i = 6'd63;
        @(posedge clk); #1;
        w_valid_i = 1'b0;
        chk("wide_valid", {63'd0, w_valid_o}, 64'd1);
        chk("wide_alu", w_alu_o, 64'hFFFF_0000_1234_5678);
        chk("wide_rd", {58'd0, w_rd_o}, 64'd63);
        @(posedge clk); #1;
        chk("wide_drain", {62'd0, w_count_o}, 64'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
